updown_counter_param_fd: RTL and testbench

//  Parametrised up/down counter with built-in clock-enable prescaler, modulus

---
 rtl/updown_counter_param_fd.sv | 87 ++++++++
 tb/tb_updown_counter_param_fd.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_param_fd.sv
// Parametrised up/down counter clocked from a single board clock.
// An internal prescaler produces a one-cycle step strobe every PRESCALE
// clocks, so no divided clock is created. The counter loads, clears, and
// counts up or down, with wrap or saturate at its limits. Tc flags a count
// step taken at a limit, which lets a following counter stage chain from it.
module updown_counter_param_fd #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 2**24,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter bit SAT      = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] In,
  input  logic             S,
  input  logic             C,
  input  logic             En,
  input  logic             F,
  output logic [WIDTH-1:0] Out,
  output logic             Tick,
  output logic             Tc
);

  // The prescaler needs at least one bit, even when PRESCALE is 1.
  localparam int               PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PLAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MAX_VAL);

  logic [PW-1:0]    pcnt;
  logic             step;
  logic             at_limit;
  logic [WIDTH-1:0] out_next;
  logic             tc_next;

  // A step edge is the last prescaler phase. With PRESCALE=1 this is always true.
  assign step = (pcnt == PLAST);

  // Free-running prescaler. Only reset restarts it; load and clear do not.
  always_ff @(posedge Clk) begin
    if (!Rst_n)
      pcnt <= '0;
    else if (step)
      pcnt <= '0;
    else
      pcnt <= pcnt + PW'(1);
  end

  // Next counter value: load > clear > gated count step > hold.
  always_comb begin
    out_next = Out;
    tc_next  = 1'b0;
    at_limit = F ? (Out == MAXV) : (Out == '0);
    if (S) begin
      // Clamp the load so that Out never exceeds MAX_VAL.
      out_next = (In > MAXV) ? MAXV : In;
    end else if (C) begin
      out_next = '0;
    end else if (step && En) begin
      tc_next = at_limit;
      if (F) begin
        if (at_limit)
          out_next = SAT ? Out : '0;
        else
          out_next = Out + WIDTH'(1);
      end else begin
        if (at_limit)
          out_next = SAT ? Out : MAXV;
        else
          out_next = Out - WIDTH'(1);
      end
    end
  end

  // Output registers. Out, Tick and Tc all update on the same edge.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Out  <= '0;
      Tick <= 1'b0;
      Tc   <= 1'b0;
    end else begin
      Out  <= out_next;
      Tick <= step;
      Tc   <= tc_next;
    end
  end

endmodule

// File: tb/tb_updown_counter_param_fd.sv
// Directed bench for updown_counter_param_fd. It drives three instances:
// wrap mode (W4/P4/M9), saturate mode (same inputs), and a fast W8/P1/M255.
module tb_updown_counter_param_fd;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [3:0] In;
  logic       S, C, En, F;
  logic [3:0] out, sat_out;
  logic       tick, tc, sat_tick, sat_tc;
  logic [7:0] f_in, f_out;
  logic       f_s, f_c, f_en, f_f, f_tick, f_tc;

  int checks = 0;
  int errors = 0;
  int tc_cnt;

  // Reference state derived from the behavioural description.
  int m_pcnt, m_out, m_sat, m_fout;
  bit m_tick, m_tc, m_stc, m_ftick, m_ftc;

  always #5 Clk = ~Clk;

  updown_counter_param_fd #(.WIDTH(4), .PRESCALE(4), .MAX_VAL(9), .SAT(1'b0)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .In(In), .S(S), .C(C), .En(En), .F(F),
    .Out(out), .Tick(tick), .Tc(tc));

  updown_counter_param_fd #(.WIDTH(4), .PRESCALE(4), .MAX_VAL(9), .SAT(1'b1)) dut_sat (
    .Clk(Clk), .Rst_n(Rst_n), .In(In), .S(S), .C(C), .En(En), .F(F),
    .Out(sat_out), .Tick(sat_tick), .Tc(sat_tc));

  updown_counter_param_fd #(.WIDTH(8), .PRESCALE(1), .MAX_VAL(255), .SAT(1'b0)) dut_fast (
    .Clk(Clk), .Rst_n(Rst_n), .In(f_in), .S(f_s), .C(f_c), .En(f_en), .F(f_f),
    .Out(f_out), .Tick(f_tick), .Tc(f_tc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: update the reference from the current inputs, then compare.
  task automatic clk1();
    bit stp;
    int ld;
    stp = (m_pcnt == 3);
    if (!Rst_n) begin
      m_pcnt = 0; m_out = 0; m_sat = 0; m_fout = 0;
      m_tick = 0; m_tc = 0; m_stc = 0; m_ftick = 0; m_ftc = 0;
    end else begin
      m_tick = stp;
      m_pcnt = stp ? 0 : m_pcnt + 1;
      ld = (In > 9) ? 9 : int'(In);
      m_tc = 0;
      m_stc = 0;
      if (S) begin
        m_out = ld; m_sat = ld;
      end else if (C) begin
        m_out = 0; m_sat = 0;
      end else if (stp && En) begin
        if (F) begin
          if (m_out == 9) begin m_out = 0; m_tc = 1; end else m_out++;
          if (m_sat == 9) m_stc = 1; else m_sat++;
        end else begin
          if (m_out == 0) begin m_out = 9; m_tc = 1; end else m_out--;
          if (m_sat == 0) m_stc = 1; else m_sat--;
        end
      end
      m_ftick = 1;
      m_ftc = 0;
      if (f_s) m_fout = int'(f_in);
      else if (f_c) m_fout = 0;
      else if (f_en) begin
        if (f_f) begin
          if (m_fout == 255) begin m_fout = 0; m_ftc = 1; end else m_fout++;
        end else begin
          if (m_fout == 0) begin m_fout = 255; m_ftc = 1; end else m_fout--;
        end
      end
    end
    @(posedge Clk);
    #1;
    chk("out", 32'(out), 32'(m_out));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("tc", 32'(tc), 32'(m_tc));
    chk("sat_out", 32'(sat_out), 32'(m_sat));
    chk("sat_tick", 32'(sat_tick), 32'(m_tick));
    chk("sat_tc", 32'(sat_tc), 32'(m_stc));
    chk("f_out", 32'(f_out), 32'(m_fout));
    chk("f_tick", 32'(f_tick), 32'(m_ftick));
    chk("f_tc", 32'(f_tc), 32'(m_ftc));
  endtask

  initial begin
    Rst_n = 1'b0; In = 4'd0; S = 1'b0; C = 1'b0; En = 1'b0; F = 1'b1;
    f_in = 8'd0; f_s = 1'b0; f_c = 1'b0; f_en = 1'b0; f_f = 1'b1;

    // Reset state
    clk1();
    clk1();
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);
    chk("reset_tc", 32'(tc), 32'd0);

    // 44 clocks counting up: 11 steps, 0..9 then wrap to 0 and 1
    Rst_n = 1'b1; En = 1'b1; F = 1'b1;
    tc_cnt = 0;
    for (int i = 0; i < 44; i++) begin
      clk1();
      if (tc === 1'b1) tc_cnt++;
    end
    chk("up_final", 32'(out), 32'd1);
    chk("up_tc_pulses", 32'(tc_cnt), 32'd1);
    chk("sat_up_final", 32'(sat_out), 32'd9);

    // Clear alone, then count down from 0 on the next step
    C = 1'b1;
    clk1();
    chk("clear_alone", 32'(out), 32'd0);
    C = 1'b0; F = 1'b0;
    clk1();
    clk1();
    clk1();
    chk("down_wrap_out", 32'(out), 32'd9);
    chk("down_wrap_tc", 32'(tc), 32'd1);
    chk("sat_down_out", 32'(sat_out), 32'd0);
    chk("sat_down_tc", 32'(sat_tc), 32'd1);

    // Load in the middle of the prescaler period, with clamping
    En = 1'b0; S = 1'b1; In = 4'd3;
    clk1();
    chk("load_3", 32'(out), 32'd3);
    In = 4'hC;
    clk1();
    chk("load_clamp", 32'(out), 32'd9);
    chk("load_no_tick", 32'(tick), 32'd0);
    S = 1'b0;
    clk1();
    chk("phase_no_tick", 32'(tick), 32'd0);
    clk1();
    chk("phase_tick", 32'(tick), 32'd1);

    // S and C together on a step edge at the limit: load wins, no Tc
    En = 1'b1; F = 1'b1;
    clk1();
    clk1();
    clk1();
    S = 1'b1; C = 1'b1; In = 4'd5;
    clk1();
    chk("sc_out", 32'(out), 32'd5);
    chk("sc_tc", 32'(tc), 32'd0);
    chk("sc_tick", 32'(tick), 32'd1);
    S = 1'b0;
    clk1();
    chk("c_only", 32'(out), 32'd0);
    C = 1'b0;

    // Reset pulse at Out=7 with the prescaler part way through a period
    En = 1'b0; S = 1'b1; In = 4'd7;
    clk1();
    S = 1'b0;
    chk("pre_reset_out", 32'(out), 32'd7);
    Rst_n = 1'b0;
    clk1();
    chk("mid_reset_out", 32'(out), 32'd0);
    Rst_n = 1'b1; En = 1'b1; F = 1'b1;
    clk1();
    clk1();
    clk1();
    chk("post_reset_no_tick", 32'(tick), 32'd0);
    clk1();
    chk("post_reset_tick", 32'(tick), 32'd1);
    chk("post_reset_out", 32'(out), 32'd1);

    // Fast instance: hold with En=0, +1 per clock, wrap both ways
    chk("fast_hold", 32'(f_out), 32'd0);
    chk("fast_tick", 32'(f_tick), 32'd1);
    f_en = 1'b1; f_f = 1'b1;
    for (int i = 0; i < 5; i++) clk1();
    chk("fast_count5", 32'(f_out), 32'd5);
    f_s = 1'b1; f_in = 8'd254;
    clk1();
    f_s = 1'b0;
    clk1();
    chk("fast_255", 32'(f_out), 32'd255);
    clk1();
    chk("fast_wrap_out", 32'(f_out), 32'd0);
    chk("fast_wrap_tc", 32'(f_tc), 32'd1);
    f_f = 1'b0;
    clk1();
    chk("fast_down_out", 32'(f_out), 32'd255);
    chk("fast_down_tc", 32'(f_tc), 32'd1);
    f_en = 1'b0;
    clk1();
    clk1();
    chk("fast_en0_hold", 32'(f_out), 32'd255);
    chk("fast_en0_tick", 32'(f_tick), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
